uart_rx_buf_ctrl: RTL and testbench

Receive-side controller for the UART receiver core: buffers received bytes in a FIFO, exposes them and the line configuration as memory-mapped registers on the system bus, and raises a level interrupt on a programmable fill threshold or overrun. Configuration writes are sequenced so the receiver core's baudrate, parity and stop-bit settings change only while the core is idle. Sits between the system-bus decoder and the UART receiver core.

---
 rtl/uart_rx_buf_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_buf_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buf_ctrl.sv
// Receive-side buffer and register block for the UART receiver core: byte FIFO,
// memory-mapped status/config registers, idle-sequenced config apply and irq.
module uart_rx_buf_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_busy_i,
  output logic [31:0] baudrate_o,
  output logic        parity_en_o,
  output logic        stopbit_o,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [31:0] ADDR_DATA   = 32'h00;
  localparam logic [31:0] ADDR_STATUS = 32'h04;
  localparam logic [31:0] ADDR_CTRL   = 32'h08;
  localparam logic [31:0] ADDR_BAUD   = 32'h0C;
  localparam logic [31:0] ADDR_PARITY = 32'h10;
  localparam logic [31:0] ADDR_STOP   = 32'h14;
  localparam logic [31:0] ADDR_CLEAR  = 32'h18;
  localparam logic [31:0] ADDR_SRST   = 32'h24;
  localparam logic [31:0] BAUD_RST    = 32'd9600;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } cfg_state_t;

  cfg_state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          irq_en;
  logic [3:0]    threshold;
  logic [3:0]    eff_threshold;
  logic [31:0]   shadow_baud;
  logic          shadow_parity, shadow_stop;

  logic rd, wr, empty, full, pop, push, drop;
  logic flush, clr_overrun, srst, cfg_write;

  assign rd          = req_i && !write_enable_i;
  assign wr          = req_i && write_enable_i;
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign pop         = rd && (addr_i == ADDR_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push        = rx_valid_i && (!full || pop);
  assign drop        = rx_valid_i && full && !pop;
  assign flush       = wr && (addr_i == ADDR_CLEAR) && write_data_i[0];
  assign clr_overrun = wr && (addr_i == ADDR_CLEAR) && write_data_i[1];
  assign srst        = wr && (addr_i == ADDR_SRST);
  assign cfg_write   = wr && ((addr_i == ADDR_BAUD) || (addr_i == ADDR_PARITY) ||
                              (addr_i == ADDR_STOP));
  assign eff_threshold = (threshold == '0) ? 4'd1 : threshold;

  always_ff @(posedge clk_i) begin
    if (push && !srst && !flush) mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overrun       <= 1'b0;
      irq_en        <= 1'b0;
      threshold     <= 4'd1;
      shadow_baud   <= BAUD_RST;
      shadow_parity <= 1'b1;
      shadow_stop   <= 1'b1;
      baudrate_o    <= BAUD_RST;
      parity_en_o   <= 1'b1;
      stopbit_o     <= 1'b1;
      irq_o         <= 1'b0;
    end else if (srst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overrun       <= 1'b0;
      irq_en        <= 1'b0;
      threshold     <= 4'd1;
      shadow_baud   <= BAUD_RST;
      shadow_parity <= 1'b1;
      shadow_stop   <= 1'b1;
      baudrate_o    <= BAUD_RST;
      parity_en_o   <= 1'b1;
      stopbit_o     <= 1'b1;
      irq_o         <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      overrun <= (overrun && !clr_overrun) || drop;
      if (wr && (addr_i == ADDR_CTRL)) begin
        irq_en    <= write_data_i[0];
        threshold <= write_data_i[7:4];
      end
      if (wr && (addr_i == ADDR_BAUD))   shadow_baud   <= write_data_i;
      if (wr && (addr_i == ADDR_PARITY)) shadow_parity <= write_data_i[0];
      if (wr && (addr_i == ADDR_STOP))   shadow_stop   <= write_data_i[0];
      if (state == APPLY) begin
        baudrate_o  <= shadow_baud;
        parity_en_o <= shadow_parity;
        stopbit_o   <= shadow_stop;
      end
      irq_o <= irq_en && ((32'(count) >= 32'(eff_threshold)) || overrun);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    state <= IDLE;
    else if (srst) state <= IDLE;
    else           state <= state_next;
  end

  // PENDING doubles as the one-cycle busy check after a write from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_write) state_next = PENDING;
      PENDING: if (!rx_busy_i) state_next = APPLY;
      APPLY:   state_next = cfg_write ? APPLY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_data_o = '0;
    if (rd) begin
      case (addr_i)
        ADDR_DATA:   if (!empty) read_data_o = {24'b0, mem[rd_ptr]};
        ADDR_STATUS: begin
          read_data_o[0]       = !empty;
          read_data_o[1]       = full;
          read_data_o[2]       = overrun;
          read_data_o[3]       = rx_busy_i;
          read_data_o[4]       = (state == PENDING);
          read_data_o[8 +: CW] = count;
        end
        ADDR_CTRL:   read_data_o = {24'b0, threshold, 3'b0, irq_en};
        ADDR_BAUD:   read_data_o = shadow_baud;
        ADDR_PARITY: read_data_o = {31'b0, shadow_parity};
        ADDR_STOP:   read_data_o = {31'b0, shadow_stop};
        default:     read_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed bench for uart_rx_buf_ctrl: FIFO order/overrun, irq threshold,
// config sequencing with busy core, soft and asynchronous reset.
module tb_uart_rx_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_busy = 1'b0;
  logic [31:0] baud;
  logic        parity_en, stopbit, irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_buf_ctrl #(.DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_enable_i(we), .addr_i(addr),
    .write_data_i(wdata), .read_data_o(rdata), .rx_data_i(rx_data),
    .rx_valid_i(rx_valid), .rx_busy_i(rx_busy), .baudrate_o(baud),
    .parity_en_o(parity_en), .stopbit_o(stopbit), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    tick();
    req = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // reset state
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_baud", baud, 32'd9600);
    check("rst_par_stop", {30'b0, parity_en, stopbit}, 32'h3);
    bus_read(32'h04, v); check("rst_status", v, 32'h0);
    bus_read(32'h08, v); check("rst_ctrl", v, 32'h10);
    bus_read(32'h0C, v); check("rst_shadow_baud", v, 32'd9600);

    // basic order and empty read
    push(8'h11); push(8'h22); push(8'h33);
    bus_read(32'h04, v); check("t1_status", v, 32'h301);
    addr = 32'h00; req = 1'b0; #1 check("t1_noread_zero", rdata, 32'h0);
    bus_read(32'h00, v); check("t1_rd0", v, 32'h11);
    bus_read(32'h00, v); check("t1_rd1", v, 32'h22);
    bus_read(32'h00, v); check("t1_rd2", v, 32'h33);
    bus_read(32'h00, v); check("t1_rd_empty", v, 32'h0);
    bus_read(32'h04, v); check("t1_status_empty", v, 32'h0);

    // overrun on the ninth byte
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    bus_read(32'h04, v); check("t2_status_full_ovr", v, 32'h807);
    for (int i = 0; i < 8; i++) begin
      bus_read(32'h00, v); check("t2_rd", v, 32'h80 + 32'(i));
    end
    bus_read(32'h04, v); check("t2_status_ovr_only", v, 32'h4);
    bus_write(32'h18, 32'h2);
    bus_read(32'h04, v); check("t2_status_cleared", v, 32'h0);

    // push and pop together while full
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    rx_valid = 1'b1; rx_data = 8'h48;
    bus_read(32'h00, v); check("t3_rd_head", v, 32'h40);
    rx_valid = 1'b0;
    bus_read(32'h04, v); check("t3_status", v, 32'h803);
    for (int i = 0; i < 8; i++) begin
      bus_read(32'h00, v); check("t3_rd", v, 32'h41 + 32'(i));
    end

    // push and pop together while empty
    rx_valid = 1'b1; rx_data = 8'h5C;
    bus_read(32'h00, v); check("t3e_rd_empty", v, 32'h0);
    rx_valid = 1'b0;
    bus_read(32'h04, v); check("t3e_status", v, 32'h101);
    bus_read(32'h00, v); check("t3e_rd", v, 32'h5C);

    // irq threshold
    bus_write(32'h08, 32'h31);
    push(8'h01); push(8'h02); tick();
    check("t4_irq_below", {31'b0, irq}, 32'h0);
    push(8'h03);
    check("t4_irq_not_yet", {31'b0, irq}, 32'h0);
    tick();
    check("t4_irq_set", {31'b0, irq}, 32'h1);
    bus_read(32'h00, v); check("t4_rd", v, 32'h01);
    tick();
    check("t4_irq_clr", {31'b0, irq}, 32'h0);
    // flush beats a same-cycle push
    rx_valid = 1'b1; rx_data = 8'h99;
    bus_write(32'h18, 32'h1);
    rx_valid = 1'b0;
    bus_read(32'h04, v); check("t4_flush_status", v, 32'h0);
    // threshold 0 behaves as 1
    bus_write(32'h08, 32'h01);
    push(8'h07); tick();
    check("t4_thr0_irq", {31'b0, irq}, 32'h1);
    bus_write(32'h18, 32'h1);
    bus_write(32'h08, 32'h0);
    tick();
    check("t4_irq_off", {31'b0, irq}, 32'h0);

    // config write while core busy
    rx_busy = 1'b1;
    bus_write(32'h0C, 32'd115200);
    tick(); tick();
    check("t6_baud_hold", baud, 32'd9600);
    bus_read(32'h04, v); check("t6_status_pending", v, 32'h18);
    rx_busy = 1'b0;
    tick();
    check("t6_baud_one_edge", baud, 32'd9600);
    tick();
    check("t6_baud_applied", baud, 32'd115200);
    bus_read(32'h04, v); check("t6_status_idle", v, 32'h0);

    // config write while core idle
    bus_write(32'h0C, 32'd19200);
    check("t5_baud_n", baud, 32'd115200);
    tick();
    check("t5_baud_n1", baud, 32'd115200);
    tick();
    check("t5_baud_n2", baud, 32'd19200);
    bus_write(32'h10, 32'h0); tick(); tick();
    check("t5_parity", {31'b0, parity_en}, 32'h0);
    bus_write(32'h14, 32'h0); tick(); tick();
    check("t5_stop", {31'b0, stopbit}, 32'h0);
    // a write landing in APPLY gets a second APPLY
    bus_write(32'h0C, 32'd1000);
    tick();
    bus_write(32'h0C, 32'd2000);
    check("t5_apply_first", baud, 32'd1000);
    tick();
    check("t5_apply_second", baud, 32'd2000);
    tick();

    // soft reset mid-operation
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    bus_write(32'h08, 32'h11);
    rx_busy = 1'b1;
    bus_write(32'h0C, 32'd19200);
    check("t7_irq_before", {31'b0, irq}, 32'h1);
    bus_read(32'h04, v); check("t7_status_before", v, 32'h519);
    rx_valid = 1'b1; rx_data = 8'hEE;
    bus_write(32'h24, 32'h0);
    rx_valid = 1'b0;
    bus_read(32'h04, v); check("t7_status_after", v, 32'h8);
    check("t7_baud", baud, 32'd9600);
    check("t7_par_stop", {30'b0, parity_en, stopbit}, 32'h3);
    check("t7_irq", {31'b0, irq}, 32'h0);
    bus_read(32'h08, v); check("t7_ctrl", v, 32'h10);
    bus_read(32'h0C, v); check("t7_shadow", v, 32'd9600);
    rx_busy = 1'b0;
    repeat (3) tick();
    check("t7_baud_no_apply", baud, 32'd9600);

    // asynchronous reset mid-cycle
    bus_write(32'h0C, 32'd4800); tick(); tick();
    check("t8_baud_set", baud, 32'd4800);
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    bus_write(32'h08, 32'h11);
    rx_busy = 1'b1;
    bus_write(32'h0C, 32'd19200);
    check("t8_irq_before", {31'b0, irq}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("t8_baud", baud, 32'd9600);
    check("t8_irq", {31'b0, irq}, 32'h0);
    req = 1'b1; we = 1'b0; addr = 32'h04;
    #1 check("t8_status_in_rst", rdata, 32'h8);
    req = 1'b0;
    tick();
    rst = 1'b1;
    rx_busy = 1'b0;
    repeat (3) tick();
    check("t8_baud_no_apply", baud, 32'd9600);
    bus_read(32'h04, v); check("t8_status_after", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
